// File: rtl/bitop_flag_capture_if.sv
// -----------------------------------------------------------------------------
// bitop_flag_capture_if
// Groups the sample input and FWFT drain signals of bitop_flag_capture.
//   in_valid  : in_flags carries a sample this cycle
//   in_flags  : [0:17], bit k = out_(k+1) of the upstream bitwise stage
//   out_valid : FIFO head is valid
//   out_ready : consumer accepts the head
//   out_flags : [0:17] FIFO head vector (0 when empty)
//   out_ts    : [15:0] head timestamp (0 when empty or timestamps disabled)
// Modports: slave = the capture block, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface bitop_flag_capture_if;
  logic        in_valid;
  logic [0:17] in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [0:17] out_flags;
  logic [15:0] out_ts;

  modport slave (
    input  in_valid,
    input  in_flags,
    input  out_ready,
    output out_valid,
    output out_flags,
    output out_ts
  );

  modport master (
    output in_valid,
    output in_flags,
    output out_ready,
    input  out_valid,
    input  out_flags,
    input  out_ts
  );
endinterface

// File: rtl/bitop_flag_capture.sv
// -----------------------------------------------------------------------------
// bitop_flag_capture
// Captures the 18 single-bit results of the 4-bit bitwise/logical stage on a
// valid strobe, optionally keeping only changed vectors, and buffers them in a
// first-word-fall-through FIFO drained by a valid/ready consumer. Samples that
// find the FIFO full are dropped and counted.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : bitop_flag_capture_if.slave (in_valid/in_flags, out_* drain)
//   level    : current FIFO occupancy, 0..DEPTH
//   drop_cnt : saturating count of dropped samples
//   overflow : sticky, set on the first drop
//
// Parameters: DEPTH (power of two, >= 2), CNT_W (drop_cnt width),
//             COMPRESS (1 = enqueue only changed vectors, 0 = every sample).
// Optional feature macro: BITOP_FLAG_CAPTURE_TIMESTAMP_EN
//   defined   : each entry stores a 16-bit free-running cycle count of its
//               push cycle, presented on out_ts for the head entry
//   undefined : no counter or storage, out_ts tied to 0
// -----------------------------------------------------------------------------
module bitop_flag_capture #(
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 8,
  parameter int COMPRESS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  bitop_flag_capture_if.slave      bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic [0:17]      last_flags_reg;
  logic             have_last_reg;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic             overflow_reg;

  // Storage has no reset: contents are only visible through the read pointer
  // while level != 0, so stale words never reach the outputs.
  logic [0:17]      flag_mem [DEPTH];

  logic chg;
  logic pop;
  logic push;
  logic drop;
  logic out_valid;

  assign out_valid = (level_reg != '0);

  always_comb begin
    chg  = 1'b0;
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    chg  = bus.in_valid &&
           ((COMPRESS == 0) || !have_last_reg || (bus.in_flags != last_flags_reg));
    pop  = out_valid && bus.out_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    push = chg && ((level_reg < FULL_LVL) || pop);
    drop = chg && !push;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      last_flags_reg <= '0;
      have_last_reg  <= 1'b0;
      drop_cnt_reg   <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      // The compare reference follows every changed sample, stored or not,
      // so a dropped value is never retried.
      if (chg) begin
        last_flags_reg <= bus.in_flags;
        have_last_reg  <= 1'b1;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_ONE;
        2'b01:   level_reg <= level_reg - LVL_ONE;
        default: level_reg <= level_reg;
      endcase
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != CNT_MAX) drop_cnt_reg <= drop_cnt_reg + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) flag_mem[wr_ptr_reg] <= bus.in_flags;
  end

  // Head is read combinationally so a freshly pushed entry is visible in the
  // cycle right after its push edge.
  assign bus.out_valid = out_valid;
  assign bus.out_flags = out_valid ? flag_mem[rd_ptr_reg] : '0;

`ifdef BITOP_FLAG_CAPTURE_TIMESTAMP_EN
  logic [15:0] cycle_cnt_reg;
  logic [15:0] ts_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt_reg <= '0;
    else     cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_ptr_reg] <= cycle_cnt_reg;
  end

  assign bus.out_ts = out_valid ? ts_mem[rd_ptr_reg] : 16'h0000;
`else
  assign bus.out_ts = 16'h0000;
`endif

  assign level    = level_reg;
  assign drop_cnt = drop_cnt_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_bitop_flag_capture.sv
// -----------------------------------------------------------------------------
// tb_bitop_flag_capture
// Scoreboard bench: expected entries are queued as stimulus is driven and
// compared against the FIFO head when the consumer pops it.
// -----------------------------------------------------------------------------
module tb_bitop_flag_capture;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic           clk;
  logic           rst;
  logic [3:0]     level;
  logic [CNT_W-1:0] drop_cnt;
  logic           overflow;

  bitop_flag_capture_if bus_if ();

  bitop_flag_capture #(
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W),
    .COMPRESS (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .level    (level),
    .drop_cnt (drop_cnt),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [0:17] flags;
    logic [15:0] ts;
  } entry_t;

  entry_t      sb_q[$];
  logic        m_have_last;
  logic [0:17] m_last;
  int          m_drop;
  logic        m_ovf;
  logic [15:0] m_cyc;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb_q.delete();
    m_have_last = 1'b0;
    m_last      = '0;
    m_drop      = 0;
    m_ovf       = 1'b0;
    m_cyc       = 16'h0000;
  endtask

  // One clock cycle: check state against the model, predict this edge, advance.
  task automatic step();
    logic   chg;
    logic   pop;
    logic   push;
    entry_t e;
    check("out_valid", 32'(bus_if.out_valid), 32'(sb_q.size() != 0));
    check("level", 32'(level), 32'(sb_q.size()));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (sb_q.size() == 0) begin
      check("empty_flags", 32'(bus_if.out_flags), 32'd0);
      check("empty_ts", 32'(bus_if.out_ts), 32'd0);
    end
    chg  = bus_if.in_valid && (!m_have_last || (bus_if.in_flags != m_last));
    pop  = (sb_q.size() != 0) && bus_if.out_ready;
    push = chg && ((sb_q.size() < DEPTH) || pop);
    if (pop) begin
      e = sb_q.pop_front();
      $display("pop  flags=%05h ts=%04h exp_flags=%05h exp_ts=%04h",
               bus_if.out_flags, bus_if.out_ts, e.flags, e.ts);
      check("head_flags", 32'(bus_if.out_flags), 32'(e.flags));
      check("head_ts", 32'(bus_if.out_ts), 32'(e.ts));
    end
    if (push) begin
      e.flags = bus_if.in_flags;
`ifdef BITOP_FLAG_CAPTURE_TIMESTAMP_EN
      e.ts = m_cyc;
`else
      e.ts = 16'h0000;
`endif
      sb_q.push_back(e);
    end
    if (chg && !push) begin
      if (m_drop < CNT_MAX) m_drop++;
      m_ovf = 1'b1;
    end
    if (chg) begin
      m_last      = bus_if.in_flags;
      m_have_last = 1'b1;
    end
    m_cyc = m_cyc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_flags", 32'(bus_if.out_flags), 32'd0);
    check("rst_out_ts", 32'(bus_if.out_ts), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    model_clear();
    bus_if.in_valid  = 1'b0;
    bus_if.in_flags  = '0;
    bus_if.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  task automatic push_alt(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_flags = (i % 2 == 0) ? 18'h00001 : 18'h00002;
      step();
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    bus_if.out_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_flags  = '0;
    bus_if.out_ready = 1'b0;
    model_clear();

    // Repeated identical sample is captured once.
    do_reset();
    bus_if.in_valid = 1'b1;
    bus_if.in_flags = 18'h00001;
    for (int i = 0; i < 3; i++) step();
    bus_if.in_valid = 1'b0;
    check("t1_level", 32'(level), 32'd1);
    check("t1_out_flags", 32'(bus_if.out_flags), 32'h00001);
    check("t1_drop_cnt", 32'(drop_cnt), 32'd0);
    drain(2);

    // Ten alternating samples into 8 entries: two drops, then ordered drain.
    do_reset();
    push_alt(10);
    check("t2_level", 32'(level), 32'd8);
    check("t2_drop_cnt", 32'(drop_cnt), 32'd2);
    check("t2_overflow", 32'(overflow), 32'd1);
    drain(8);
    check("t2_out_valid_end", 32'(bus_if.out_valid), 32'd0);

    // Full FIFO with simultaneous pop accepts a new value, read out last.
    do_reset();
    push_alt(8);
    bus_if.in_valid  = 1'b1;
    bus_if.in_flags  = 18'h00003;
    bus_if.out_ready = 1'b1;
    step();
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    check("t3_level", 32'(level), 32'd8);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd0);
    drain(7);
    check("t3_last_flags", 32'(bus_if.out_flags), 32'h00003);
    drain(1);
    check("t3_out_valid_end", 32'(bus_if.out_valid), 32'd0);

    // Six drops saturate a 2-bit counter.
    do_reset();
    push_alt(14);
    check("t4_drop_cnt_sat", 32'(drop_cnt), 32'd3);
    check("t4_overflow", 32'(overflow), 32'd1);
    drain(8);

    // Reset with five entries buffered; pre-reset last value recaptured.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_flags = 18'(32'h10 + i);
      step();
    end
    bus_if.in_valid = 1'b0;
    check("t5_level_pre", 32'(level), 32'd5);
    do_reset();
    bus_if.in_valid = 1'b1;
    bus_if.in_flags = 18'h00014;
    step();
    bus_if.in_valid = 1'b0;
    check("t5_level_post", 32'(level), 32'd1);
    check("t5_out_flags", 32'(bus_if.out_flags), 32'h00014);
    drain(1);

    // Pushes on cycles 3 and 7 after reset release.
    do_reset();
    for (int i = 0; i < 3; i++) step();
    bus_if.in_valid = 1'b1;
    bus_if.in_flags = 18'h2aaaa;
    step();
    bus_if.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus_if.in_valid = 1'b1;
    bus_if.in_flags = 18'h15555;
    step();
    bus_if.in_valid = 1'b0;
`ifdef BITOP_FLAG_CAPTURE_TIMESTAMP_EN
    check("t6_ts_first", 32'(bus_if.out_ts), 32'd3);
`else
    check("t6_ts_first", 32'(bus_if.out_ts), 32'd0);
`endif
    drain(1);
`ifdef BITOP_FLAG_CAPTURE_TIMESTAMP_EN
    check("t6_ts_second", 32'(bus_if.out_ts), 32'd7);
`else
    check("t6_ts_second", 32'(bus_if.out_ts), 32'd0);
`endif
    drain(1);

    // Random traffic from a small value set so repeats and full periods occur.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bus_if.in_valid  = ($urandom_range(0, 3) != 0);
      bus_if.in_flags  = 18'(32'd1 << $urandom_range(0, 3));
      bus_if.out_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    bus_if.in_valid = 1'b0;
    drain(DEPTH + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
